// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM: converts push/pop into RAM write/read
// requests and tracks pointers, occupancy, status and sticky error flags.
module dpram_fifo_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 2**ADDR_SIZE,
    parameter int AFULL_TH  = DEPTH-2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic                 pop_valid,
    output logic [DATA_SIZE-1:0] pop_data,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 wr,
    output logic [ADDR_SIZE-1:0] addr_wr,
    output logic [DATA_SIZE-1:0] data_wr,
    output logic                 rd,
    output logic [ADDR_SIZE-1:0] addr_rd,
    input  logic [DATA_SIZE-1:0] data_rd
);

    localparam logic [ADDR_SIZE:0]   DEPTH_C  = DEPTH[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0]   AFULL_C  = AFULL_TH[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0]   AEMPTY_C = AEMPTY_TH[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE-1:0] PTR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    logic [ADDR_SIZE-1:0] wptr_q, wptr_d;
    logic [ADDR_SIZE-1:0] rptr_q, rptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic                 pop_valid_q, pop_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 push_acc, pop_acc;

    // Handshake: a push/pop is taken in any cycle where it is asserted and the FIFO
    // is not full/empty and no flush is active; a refused request has no effect
    // beyond the sticky error flag. Popped data follows one cycle later with pop_valid.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign pop_valid    = pop_valid_q;
    assign pop_data     = data_rd;

    always_comb begin
        push_acc    = push & ~full & ~flush;
        pop_acc     = pop & ~empty & ~flush;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        pop_valid_d = pop_acc;
        overflow_d  = overflow_q | (push & full);
        underflow_d = underflow_q | (pop & empty);
        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_acc) wptr_d = wptr_q + PTR_ONE;
            if (pop_acc)  rptr_d = rptr_q + PTR_ONE;
            if (push_acc && !pop_acc) count_d = count_q + 1'b1;
            if (pop_acc && !push_acc) count_d = count_q - 1'b1;
        end
    end

    // RAM requests are held off while reset is asserted, even if push is high.
    assign wr      = push_acc & rst;
    assign addr_wr = wptr_q;
    assign data_wr = push_data;
    assign rd      = pop_acc & rst;
    assign addr_rd = rptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl: a RAM model, a queue-based reference model checked
// on every falling edge, and literal expectations at the scenario milestones.
module tb_dpram_fifo_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        push;
  logic [31:0] push_data;
  logic        pop;
  logic        pop_valid;
  logic [31:0] pop_data;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;
  logic        wr;
  logic [3:0]  addr_wr;
  logic [31:0] data_wr;
  logic        rd;
  logic [3:0]  addr_rd;
  logic [31:0] data_rd;

  int n_checks = 0;
  int n_fail   = 0;

  dpram_fifo_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data),
    .pop(pop), .pop_valid(pop_valid), .pop_data(pop_data), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .wr(wr), .addr_wr(addr_wr),
    .data_wr(data_wr), .rd(rd), .addr_rd(addr_rd), .data_rd(data_rd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dual-port RAM: synchronous write, registered read
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (wr) mem[addr_wr] <= data_wr;
    if (rd) data_rd <= mem[addr_rd];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: FIFO contents as a queue, RAM addresses as plain counters mod 16
  logic [31:0] exp_q[$];
  int          m_wp, m_rp;
  bit          m_ovf, m_unf, m_pv;
  logic [31:0] m_pdata;

  always @(posedge clk or negedge rst) begin
    int sz;
    bit p_ok, q_ok;
    if (!rst) begin
      exp_q.delete();
      m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0; m_pv = 0;
    end else begin
      sz   = exp_q.size();
      p_ok = push && sz < 16 && !flush;
      q_ok = pop && sz > 0 && !flush;
      m_pv = q_ok;
      if (flush) begin
        exp_q.delete();
        m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
      end else begin
        if (q_ok) begin
          m_pdata = exp_q.pop_front();
          m_rp = (m_rp + 1) % 16;
        end
        if (p_ok) begin
          exp_q.push_back(push_data);
          m_wp = (m_wp + 1) % 16;
        end
        if (push && sz == 16) m_ovf = 1;
        if (pop && sz == 0) m_unf = 1;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    int sz;
    bit p_ok, q_ok;
    sz   = exp_q.size();
    p_ok = rst && push && sz < 16 && !flush;
    q_ok = rst && pop && sz > 0 && !flush;
    chk("count", 32'(count), 32'(sz));
    chk("full", 32'(full), 32'(sz == 16));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("almost_full", 32'(almost_full), 32'(sz >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("wr", 32'(wr), 32'(p_ok));
    chk("rd", 32'(rd), 32'(q_ok));
    chk("pop_valid", 32'(pop_valid), 32'(m_pv));
    if (p_ok) begin
      chk("addr_wr", 32'(addr_wr), 32'(m_wp));
      chk("data_wr", data_wr, push_data);
    end
    if (q_ok) chk("addr_rd", 32'(addr_rd), 32'(m_rp));
    if (m_pv) chk("pop_data", pop_data, m_pdata);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      push = 1'b1; pop = 1'b0; push_data = base + 32'(i);
      step();
    end
    push = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      pop = 1'b1; push = 1'b0;
      step();
    end
    pop = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; push = 1'b1; pop = 1'b0; push_data = 32'h0;

    // 1: reset with push held
    repeat (2) step();
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("first_wr", 32'(wr), 32'd1);
    chk("first_addr_wr", 32'(addr_wr), 32'd0);
    push = 1'b0;
    step();

    // 2: fill with 0xA0..0xAF, then overflow
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; push_data = 32'hA0 + 32'(i);
      step();
      if (i == 12) chk("afull_at13", 32'(almost_full), 32'd0);
      if (i == 13) chk("afull_at14", 32'(almost_full), 32'd1);
    end
    push_data = 32'hFF;
    chk("full16", 32'(full), 32'd1);
    chk("count16", 32'(count), 32'd16);
    chk("wr_when_full", 32'(wr), 32'd0);
    step();
    chk("overflow_set", 32'(overflow), 32'd1);
    push = 1'b0;

    // 3: drain in order, then underflow
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      step();
      chk("drain_valid", 32'(pop_valid), 32'd1);
      chk("drain_data", pop_data, 32'hA0 + 32'(i));
    end
    chk("drained_empty", 32'(empty), 32'd1);
    chk("rd_when_empty", 32'(rd), 32'd0);
    step();
    chk("underflow_set", 32'(underflow), 32'd1);
    chk("no_valid_on_empty_pop", 32'(pop_valid), 32'd0);
    pop = 1'b0;

    // 4: count=5 with both pointers about to wrap, simultaneous push/pop
    push_n(15, 32'hB0);
    pop_n(10);
    chk("count5", 32'(count), 32'd5);
    for (int k = 0; k < 8; k++) begin
      push = 1'b1; pop = 1'b1; push_data = 32'hC0 + 32'(k);
      #1;
      if (k == 0) chk("addr_wr_15", 32'(addr_wr), 32'd15);
      if (k == 1) chk("addr_wr_wrap", 32'(addr_wr), 32'd0);
      if (k == 5) chk("addr_rd_15", 32'(addr_rd), 32'd15);
      if (k == 6) chk("addr_rd_wrap", 32'(addr_rd), 32'd0);
      step();
      if (k == 0) chk("stream_first", pop_data, 32'hBA);
      if (k == 5) chk("stream_sixth", pop_data, 32'hC0);
    end
    push = 1'b0; pop = 1'b0;
    chk("count_steady5", 32'(count), 32'd5);

    // clear flags, then 5: full + simultaneous push/pop
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ovf_clr", 32'(overflow), 32'd0);
    chk("flush_unf_clr", 32'(underflow), 32'd0);
    push_n(16, 32'hD0);
    push = 1'b1; pop = 1'b1; push_data = 32'hEE;
    step();
    push = 1'b0; pop = 1'b0;
    chk("full_pp_count", 32'(count), 32'd15);
    chk("full_pp_ovf", 32'(overflow), 32'd1);
    chk("full_pp_data", pop_data, 32'hD0);

    // 6: count=9, flush with push/pop held, then reset mid-burst
    pop_n(6);
    chk("count9", 32'(count), 32'd9);
    flush = 1'b1; push = 1'b1; pop = 1'b1; push_data = 32'h77;
    #1;
    chk("flush_wr", 32'(wr), 32'd0);
    chk("flush_rd", 32'(rd), 32'd0);
    chk("flush_inflight_valid", 32'(pop_valid), 32'd1);
    step();
    flush = 1'b0; pop = 1'b0; push_data = 32'h55;
    chk("post_flush_count", 32'(count), 32'd0);
    chk("post_flush_empty", 32'(empty), 32'd1);
    chk("post_flush_ovf", 32'(overflow), 32'd0);
    #1;
    chk("post_flush_addr_wr", 32'(addr_wr), 32'd0);
    push_n(3, 32'h55);
    pop = 1'b1; push = 1'b1; push_data = 32'h60;
    step();
    #3 rst = 1'b0;
    #1;
    chk("async_pop_valid", 32'(pop_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_wr", 32'(wr), 32'd0);
    chk("async_rd", 32'(rd), 32'd0);
    push = 1'b0; pop = 1'b0;
    step();
    rst = 1'b1;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
